// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter_if : request/response channels of the shared-ALU arbiter
// Revision: 1.0
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 7
);
    logic            req0_valid;
    logic            req0_ready;
    logic [OPW-1:0]  req0_op;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;

    logic            req1_valid;
    logic            req1_ready;
    logic [OPW-1:0]  req1_op;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;

    logic            rsp0_valid;
    logic            rsp1_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter : round-robin sharing of one combinational ALU by two
//                     requesters, with a latched valid/ready response.
// Revision: 1.0
// ============================================================================
module alu_share_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 7
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    alu_share_arbiter_if.slave   req_if,
    output logic [1:0]           alu_op,
    output logic [2:0]           alu_func3,
    output logic                 alu_opc5,
    output logic                 alu_func7,
    output logic [XLEN-1:0]      alu_src_a,
    output logic [XLEN-1:0]      alu_src_b,
    input  wire logic [XLEN-1:0] alu_result
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            grant;
    logic            accept;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        zero_d       = zero_q;
        grant        = 1'b0;
        accept       = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (req_if.req0_valid && req_if.req1_valid) begin
                    grant = ~last_grant_q;
                end else begin
                    grant = req_if.req1_valid;
                end
                accept = (req_if.req0_valid || req_if.req1_valid) && rst_n;
                if (accept) begin
                    state_d      = ISSUE;
                    owner_d      = grant;
                    last_grant_d = grant;
                    op_d         = grant ? req_if.req1_op : req_if.req0_op;
                    a_d          = grant ? req_if.req1_a  : req_if.req0_a;
                    b_d          = grant ? req_if.req1_b  : req_if.req0_b;
                end
            end
            ISSUE: begin
                result_d = alu_result;
                zero_d   = (alu_result == '0);
                state_d  = RESP;
            end
            RESP: begin
                if (req_if.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

    assign req_if.req0_ready = accept && !grant;
    assign req_if.req1_ready = accept &&  grant;
    assign req_if.rsp0_valid = (state_q == RESP) && !owner_q;
    assign req_if.rsp1_valid = (state_q == RESP) &&  owner_q;
    assign req_if.rsp_result = result_q;
    assign req_if.rsp_zero   = zero_q;

    // The ALU is fed straight from the latched payload so it only moves on accept.
    assign alu_op    = op_q[6:5];
    assign alu_func3 = op_q[4:2];
    assign alu_opc5  = op_q[1];
    assign alu_func7 = op_q[0];
    assign alu_src_a = a_q;
    assign alu_src_b = b_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_share_arbiter : directed and randomized bench with a behavioural
//                        transaction model of the shared-ALU arbiter.
// Revision: 1.0
// ============================================================================
module tb_alu_share_arbiter;
    localparam int XLEN = 32;
    localparam int OPW  = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

    logic [1:0]      alu_op;
    logic [2:0]      alu_func3;
    logic            alu_opc5;
    logic            alu_func7;
    logic [XLEN-1:0] alu_src_a;
    logic [XLEN-1:0] alu_src_b;
    logic [XLEN-1:0] alu_result;

    // Reference ALU; the 2'b11 code stands in for the decoder's undefined control.
    function automatic logic [31:0] alu_fn(input logic [6:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (op[6:5])
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: begin
                case (op[4:2])
                    3'b000: r = (op[1] && op[0]) ? a - b : a + b;
                    3'b001: r = a << b[4:0];
                    3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'b011: r = (a < b) ? 32'd1 : 32'd0;
                    3'b100: r = a ^ b;
                    3'b101: r = op[0] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'b110: r = a | b;
                    default: r = a & b;
                endcase
            end
            default: r = a ^ b ^ 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    assign alu_result = alu_fn({alu_op, alu_func3, alu_opc5, alu_func7}, alu_src_a, alu_src_b);

    alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (bus),
        .alu_op     (alu_op),
        .alu_func3  (alu_func3),
        .alu_opc5   (alu_opc5),
        .alu_func7  (alu_func7),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_result (alu_result)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: busy from accept until the response is consumed;
    // age 1 is the ALU cycle, age >= 2 is the response phase.
    initial begin
        bit          m_busy, m_owner, m_last, m_zero, g, e_r0, e_r1;
        int          m_age;
        logic [6:0]  m_op;
        logic [31:0] m_a, m_b, m_res;
        m_busy = 0; m_owner = 0; m_last = 1; m_zero = 0; m_age = 0;
        m_op = 0; m_a = 0; m_b = 0; m_res = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_owner = 0; m_last = 1; m_zero = 0; m_age = 0;
                m_op = 0; m_a = 0; m_b = 0; m_res = 0;
            end
            e_r0 = 0;
            e_r1 = 0;
            if (rst_n && !m_busy && (bus.req0_valid || bus.req1_valid)) begin
                g    = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
                e_r0 = !g;
                e_r1 = g;
            end
            chk("ready0", 32'(bus.req0_ready), 32'(e_r0));
            chk("ready1", 32'(bus.req1_ready), 32'(e_r1));
            chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_busy && m_age >= 2 && !m_owner));
            chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_busy && m_age >= 2 && m_owner));
            chk("rsp_result", bus.rsp_result, m_res);
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
            chk("alu_fields", 32'({alu_op, alu_func3, alu_opc5, alu_func7}), 32'(m_op));
            chk("alu_src_a", alu_src_a, m_a);
            chk("alu_src_b", alu_src_b, m_b);
            if (rst_n) begin
                if (!m_busy) begin
                    if (e_r0 || e_r1) begin
                        m_busy  = 1;
                        m_age   = 1;
                        m_owner = e_r1;
                        m_last  = e_r1;
                        m_op    = e_r1 ? bus.req1_op : bus.req0_op;
                        m_a     = e_r1 ? bus.req1_a  : bus.req0_a;
                        m_b     = e_r1 ? bus.req1_b  : bus.req0_b;
                    end
                end else if (m_age == 1) begin
                    m_age  = 2;
                    m_res  = alu_fn(m_op, m_a, m_b);
                    m_zero = (m_res == 0);
                end else if (bus.rsp_ready) begin
                    m_busy = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] rand_op();
        logic [1:0] o;
        o = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        return {o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
    endfunction

    initial begin
        bit acc0, acc1;
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp_ready  = 0;

        // Reset holds ready low even with a request pending.
        bus.req0_valid = 1; bus.req0_op = 7'b00_000_0_0; bus.req0_a = 5; bus.req0_b = 7;
        repeat (2) cyc();
        #2;
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_alu_a", alu_src_a, 0);
        chk("rst_result", bus.rsp_result, 0);

        // ADD 5+7 on req0 with the accept/ALU/response timeline.
        cyc(); rst_n = 1; #2;
        chk("t1_ready0", 32'(bus.req0_ready), 1);
        cyc(); bus.req0_valid = 0; #2;
        chk("t1_alu_a", alu_src_a, 5);
        chk("t1_alu_b", alu_src_b, 7);
        chk("t1_rsp0_early", 32'(bus.rsp0_valid), 0);
        cyc(); #2;
        chk("t1_rsp0", 32'(bus.rsp0_valid), 1);
        chk("t1_result", bus.rsp_result, 12);
        chk("t1_zero", 32'(bus.rsp_zero), 0);

        // Response backpressure with a new req0 waiting.
        bus.req0_valid = 1; bus.req0_op = 7'b00_000_0_0; bus.req0_a = 1; bus.req0_b = 2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready0", 32'(bus.req0_ready), 0);
            chk("bp_result", bus.rsp_result, 12);
            cyc(); #2;
        end
        bus.rsp_ready = 1;
        chk("bp_ready0_last", 32'(bus.req0_ready), 0);
        cyc(); bus.rsp_ready = 0; #2;
        chk("bp_accept", 32'(bus.req0_ready), 1);
        cyc(); bus.req0_valid = 0;
        cyc(); #2;
        chk("bp_result2", bus.rsp_result, 3);
        bus.rsp_ready = 1;
        cyc(); bus.rsp_ready = 0;

        // SUB 9-9 on req1 alone.
        bus.req1_valid = 1; bus.req1_op = 7'b01_000_0_0; bus.req1_a = 9; bus.req1_b = 9; #2;
        chk("sub_ready1", 32'(bus.req1_ready), 1);
        chk("sub_ready0", 32'(bus.req0_ready), 0);
        cyc(); bus.req1_valid = 0;
        cyc(); #2;
        chk("sub_rsp1", 32'(bus.rsp1_valid), 1);
        chk("sub_rsp0", 32'(bus.rsp0_valid), 0);
        chk("sub_result", bus.rsp_result, 0);
        chk("sub_zero", 32'(bus.rsp_zero), 1);
        bus.rsp_ready = 1;
        cyc(); bus.rsp_ready = 0;

        // Two ties in a row: req0 then req1.
        bus.req0_valid = 1; bus.req0_op = 0; bus.req0_a = 1; bus.req0_b = 1;
        bus.req1_valid = 1; bus.req1_op = 0; bus.req1_a = 2; bus.req1_b = 2; #2;
        chk("rr1_ready0", 32'(bus.req0_ready), 1);
        chk("rr1_ready1", 32'(bus.req1_ready), 0);
        cyc();
        cyc(); #2;
        chk("rr1_rsp0", 32'(bus.rsp0_valid), 1);
        chk("rr1_result", bus.rsp_result, 2);
        bus.rsp_ready = 1;
        cyc(); bus.rsp_ready = 0; #2;
        chk("rr2_ready1", 32'(bus.req1_ready), 1);
        chk("rr2_ready0", 32'(bus.req0_ready), 0);
        cyc();
        cyc(); #2;
        chk("rr2_rsp1", 32'(bus.rsp1_valid), 1);
        chk("rr2_result", bus.rsp_result, 4);
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
        cyc(); bus.rsp_ready = 0;

        // R-type SRA passes its fields through untouched.
        bus.req0_valid = 1; bus.req0_op = 7'b10_101_1_1; bus.req0_a = 32'h8000_0000; bus.req0_b = 4;
        cyc(); bus.req0_valid = 0; #2;
        chk("sra_alu_op", 32'(alu_op), 2);
        chk("sra_func3", 32'(alu_func3), 5);
        chk("sra_opc5", 32'(alu_opc5), 1);
        chk("sra_func7", 32'(alu_func7), 1);
        chk("sra_alu_a", alu_src_a, 32'h8000_0000);
        chk("sra_alu_b", alu_src_b, 4);
        cyc(); #2;
        chk("sra_result", bus.rsp_result, 32'hF800_0000);
        chk("sra_zero", 32'(bus.rsp_zero), 0);
        bus.rsp_ready = 1;
        cyc(); bus.rsp_ready = 0;

        // Reset while the ALU is being driven drops the transaction.
        bus.req0_valid = 1; bus.req0_op = 0; bus.req0_a = 3; bus.req0_b = 4;
        cyc(); bus.req0_valid = 0; rst_n = 0; #2;
        chk("rsti_rsp0", 32'(bus.rsp0_valid), 0);
        chk("rsti_alu_a", alu_src_a, 0);
        chk("rsti_result", bus.rsp_result, 0);
        cyc(); #2;
        chk("rsti_rsp0_b", 32'(bus.rsp0_valid), 0);
        cyc(); rst_n = 1;
        bus.req1_valid = 1; bus.req1_op = 0; bus.req1_a = 10; bus.req1_b = 20; #2;
        chk("rsti_ready1", 32'(bus.req1_ready), 1);
        cyc(); bus.req1_valid = 0;
        cyc(); #2;
        chk("rsti_rsp1", 32'(bus.rsp1_valid), 1);
        chk("rsti_result2", bus.rsp_result, 30);
        bus.rsp_ready = 1;
        cyc(); bus.rsp_ready = 0;

        // Randomized traffic; requesters hold their payload until accepted.
        acc0 = 0;
        acc1 = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!bus.req0_valid || acc0) begin
                bus.req0_valid = ($urandom_range(0, 2) != 0);
                bus.req0_op    = rand_op();
                bus.req0_a     = $urandom;
                bus.req0_b     = ($urandom_range(0, 3) == 0) ? bus.req0_a : $urandom;
            end
            if (!bus.req1_valid || acc1) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_op    = rand_op();
                bus.req1_a     = $urandom;
                bus.req1_b     = ($urandom_range(0, 3) == 0) ? bus.req1_a : $urandom;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 399) != 0);
            #2;
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            cyc();
        end
        rst_n = 1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
